// File: rtl/pulse_group_if.sv
// pulse_group_if
//  Host/trigger side signals of the pulse group counter.
//  master : drives Start, Abort, Capture_En, Trigger_in; observes the status outputs
//  slave  : the counter itself
//  Signals:
//   Start, Abort    one-cycle host requests (sync to clk)
//   Capture_En      global capture enable from group control
//   Trigger_in      external laser trigger, asynchronous to clk
//   Pulse_counts    index of current pulse in group (0 = none yet)
//   Pulse_valid     capture window open
//   Busy            group in progress
//   Group_done      one-cycle pulse when the group completes
//   Trig_miss       one-cycle pulse when a trigger edge was ignored
interface pulse_group_if;
  logic        Start;
  logic        Abort;
  logic        Capture_En;
  logic        Trigger_in;
  logic [15:0] Pulse_counts;
  logic        Pulse_valid;
  logic        Busy;
  logic        Group_done;
  logic        Trig_miss;

  modport master (
    output Start, Abort, Capture_En, Trigger_in,
    input  Pulse_counts, Pulse_valid, Busy, Group_done, Trig_miss
  );

  modport slave (
    input  Start, Abort, Capture_En, Trigger_in,
    output Pulse_counts, Pulse_valid, Busy, Group_done, Trig_miss
  );
endinterface

// File: rtl/pulse_group_counter.sv
// pulse_group_counter
//  Counts accepted laser trigger pulses within one accumulation group and opens a
//  fixed-length capture window (Pulse_valid) per accepted pulse.
//  Ports:
//   clk   system/ADC clock
//   rst   asynchronous, active-high reset
//   bus   pulse_group_if.slave (Start/Abort/Capture_En/Trigger_in in,
//         Pulse_counts/Pulse_valid/Busy/Group_done/Trig_miss out)
//
//  state  | meaning
//  IDLE   | no group; Pulse_counts holds its last value
//  ARMED  | group running, waiting for the next trigger edge
//  WINDOW | capture window open for CAPTURE_LEN cycles
//  DONE   | last window closed; Group_done issued on the way back to IDLE
module pulse_group_counter #(
  parameter int unsigned TOTAL_PULSE = 4,
  parameter int unsigned CAPTURE_LEN = 1024,
  parameter int unsigned WIN_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  pulse_group_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] WINDOW = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [15:0]      LAST_PULSE = 16'(TOTAL_PULSE);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(CAPTURE_LEN - 1);

  logic [1:0]       state;
  logic             trig_sync1;
  logic             trig_sync2;
  logic             trig_sync3;
  logic             trig_rise;
  logic             cancel;
  logic [WIN_W-1:0] win_cnt;
  logic [15:0]      pulse_counts;
  logic             pulse_valid;
  logic             busy;
  logic             group_done;
  logic             trig_miss;

  // Two flops resolve metastability on the asynchronous trigger; the third
  // holds the previous synchronized level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sync1 <= 1'b0;
      trig_sync2 <= 1'b0;
      trig_sync3 <= 1'b0;
    end else begin
      trig_sync1 <= bus.Trigger_in;
      trig_sync2 <= trig_sync1;
      trig_sync3 <= trig_sync2;
    end
  end

  assign trig_rise = trig_sync2 & ~trig_sync3;

  // Abort and loss of Capture_En both cancel an active group; they outrank
  // trigger edges and window completion in the same cycle.
  assign cancel = bus.Abort | ~bus.Capture_En;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      win_cnt      <= '0;
      pulse_counts <= '0;
      pulse_valid  <= 1'b0;
      busy         <= 1'b0;
      group_done   <= 1'b0;
      trig_miss    <= 1'b0;
    end else begin
      group_done <= 1'b0;
      trig_miss  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && bus.Capture_En && !bus.Abort) begin
            state        <= ARMED;
            pulse_counts <= '0;
            busy         <= 1'b1;
          end
        end

        ARMED: begin
          if (cancel) begin
            state        <= IDLE;
            win_cnt      <= '0;
            pulse_counts <= '0;
            pulse_valid  <= 1'b0;
            busy         <= 1'b0;
          end else if (trig_rise) begin
            state        <= WINDOW;
            pulse_counts <= pulse_counts + 16'd1;
            pulse_valid  <= 1'b1;
            win_cnt      <= '0;
          end
        end

        WINDOW: begin
          if (cancel) begin
            state        <= IDLE;
            win_cnt      <= '0;
            pulse_counts <= '0;
            pulse_valid  <= 1'b0;
            busy         <= 1'b0;
          end else begin
            // Any edge seen while the window is open, including its last
            // cycle, is dropped and flagged.
            trig_miss <= trig_rise;
            if (win_cnt == WIN_LAST) begin
              pulse_valid <= 1'b0;
              state       <= (pulse_counts == LAST_PULSE) ? DONE : ARMED;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          // Group_done is issued on leaving DONE so a cancel arriving here
          // can still suppress it.
          if (cancel) begin
            state        <= IDLE;
            win_cnt      <= '0;
            pulse_counts <= '0;
            pulse_valid  <= 1'b0;
            busy         <= 1'b0;
          end else begin
            state      <= IDLE;
            group_done <= 1'b1;
            busy       <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Pulse_counts = pulse_counts;
  assign bus.Pulse_valid  = pulse_valid;
  assign bus.Busy         = busy;
  assign bus.Group_done   = group_done;
  assign bus.Trig_miss    = trig_miss;

endmodule

// File: tb/tb_pulse_group_counter.sv
// tb_pulse_group_counter
//  Directed group scenarios followed by random traffic, all compared cycle by
//  cycle against a behavioural model of the group rules.
module tb_pulse_group_counter;
  localparam int TP = 4;
  localparam int CL = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pulse_group_if pg_if ();

  pulse_group_counter #(
    .TOTAL_PULSE (TP),
    .CAPTURE_LEN (CL),
    .WIN_W       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pg_if.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gd_seen   = 0;
  int miss_seen = 0;

  // model: trigger samples (newest in [0]), group progress as plain counters
  logic [2:0] m_samp;
  bit m_active, m_done_pend;
  int m_pulses, m_win_left;
  bit e_valid, e_busy, e_done, e_miss;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_samp = '0;
    m_active = 0; m_done_pend = 0;
    m_pulses = 0; m_win_left = 0;
    e_valid = 0; e_busy = 0; e_done = 0; e_miss = 0;
  endtask

  // A trigger edge reaches the group logic when the sample two edges back is
  // high and the one three edges back is low.
  task automatic model_edge();
    bit rise;
    rise = m_samp[1] & ~m_samp[2];
    m_samp = {m_samp[1:0], pg_if.Trigger_in};
    e_miss = 0;
    e_done = 0;
    if (m_active && (pg_if.Abort || !pg_if.Capture_En)) begin
      m_active = 0; m_done_pend = 0; m_win_left = 0; m_pulses = 0;
      e_valid = 0; e_busy = 0;
    end else if (!m_active) begin
      if (pg_if.Start && pg_if.Capture_En && !pg_if.Abort) begin
        m_active = 1; e_busy = 1; m_pulses = 0;
      end
    end else if (m_done_pend) begin
      m_done_pend = 0; m_active = 0; e_busy = 0; e_done = 1;
    end else if (m_win_left > 0) begin
      e_miss = rise;
      m_win_left--;
      if (m_win_left == 0) begin
        e_valid = 0;
        if (m_pulses == TP) m_done_pend = 1;
      end
    end else if (rise) begin
      m_pulses++;
      e_valid = 1;
      m_win_left = CL;
    end
  endtask

  task automatic compare_all();
    chk("counts", int'(pg_if.Pulse_counts), m_pulses);
    chk("valid",  int'(pg_if.Pulse_valid),  int'(e_valid));
    chk("busy",   int'(pg_if.Busy),         int'(e_busy));
    chk("done",   int'(pg_if.Group_done),   int'(e_done));
    chk("miss",   int'(pg_if.Trig_miss),    int'(e_miss));
    gd_seen   += int'(pg_if.Group_done);
    miss_seen += int'(pg_if.Trig_miss);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse_start();
    pg_if.Start = 1'b1;
    step(1);
    pg_if.Start = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_counts", int'(pg_if.Pulse_counts), 0);
    chk("rst_valid",  int'(pg_if.Pulse_valid),  0);
    chk("rst_busy",   int'(pg_if.Busy),         0);
    chk("rst_done",   int'(pg_if.Group_done),   0);
    chk("rst_miss",   int'(pg_if.Trig_miss),    0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start, then TP triggers 20 clk apart; checks count and window per pulse.
  task automatic run_group();
    int g0;
    g0 = gd_seen;
    pulse_start();
    for (int k = 1; k <= TP; k++) begin
      pg_if.Trigger_in = 1'b1;
      step(3);
      chk("grp_count", int'(pg_if.Pulse_counts), k);
      chk("grp_valid", int'(pg_if.Pulse_valid), 1);
      pg_if.Trigger_in = 1'b0;
      step(17);
    end
    chk("grp_done_cnt", gd_seen - g0, 1);
    chk("grp_busy_end", int'(pg_if.Busy), 0);
    chk("grp_count_end", int'(pg_if.Pulse_counts), TP);
  endtask

  initial begin
    int n, m0, g0, trig_cnt, cap_cnt;
    pg_if.Start      = 1'b0;
    pg_if.Abort      = 1'b0;
    pg_if.Capture_En = 1'b1;
    pg_if.Trigger_in = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("init_counts", int'(pg_if.Pulse_counts), 0);
    chk("init_valid",  int'(pg_if.Pulse_valid),  0);
    chk("init_busy",   int'(pg_if.Busy),         0);
    chk("init_done",   int'(pg_if.Group_done),   0);
    chk("init_miss",   int'(pg_if.Trig_miss),    0);
    @(negedge clk);
    rst = 1'b0;
    step(3);

    // full group
    run_group();
    step(5);

    // trigger-to-window latency: trigger raised between edges N and N+1
    pulse_start();
    pg_if.Trigger_in = 1'b1;
    n = 0;
    while (pg_if.Pulse_valid !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("latency", n, 3);
    chk("latency_count", int'(pg_if.Pulse_counts), 1);
    pg_if.Trigger_in = 1'b0;
    step(17);

    // trigger inside window 2
    pg_if.Trigger_in = 1'b1;
    step(3);
    pg_if.Trigger_in = 1'b0;
    step(2);
    pg_if.Trigger_in = 1'b1;
    m0 = miss_seen;
    step(3);
    pg_if.Trigger_in = 1'b0;
    step(4);
    chk("win_miss_cnt", miss_seen - m0, 1);
    chk("win_miss_count", int'(pg_if.Pulse_counts), 2);
    step(8);

    // abort together with start inside window 3
    pg_if.Trigger_in = 1'b1;
    step(3);
    pg_if.Trigger_in = 1'b0;
    step(2);
    g0 = gd_seen;
    pg_if.Abort = 1'b1;
    pg_if.Start = 1'b1;
    step(1);
    pg_if.Abort = 1'b0;
    pg_if.Start = 1'b0;
    chk("abort_busy",   int'(pg_if.Busy),         0);
    chk("abort_counts", int'(pg_if.Pulse_counts), 0);
    chk("abort_valid",  int'(pg_if.Pulse_valid),  0);
    step(10);
    chk("abort_no_done", gd_seen - g0, 0);
    run_group();

    // capture disabled
    pg_if.Capture_En = 1'b0;
    pulse_start();
    step(2);
    chk("capen_idle_busy", int'(pg_if.Busy), 0);
    pg_if.Capture_En = 1'b1;
    pulse_start();
    step(2);
    pg_if.Capture_En = 1'b0;
    step(1);
    pg_if.Capture_En = 1'b1;
    chk("capen_drop_busy",   int'(pg_if.Busy), 0);
    chk("capen_drop_counts", int'(pg_if.Pulse_counts), 0);
    step(3);

    // reset in window 2, then triggers without Start
    pulse_start();
    pg_if.Trigger_in = 1'b1; step(3); pg_if.Trigger_in = 1'b0; step(17);
    pg_if.Trigger_in = 1'b1; step(3); pg_if.Trigger_in = 1'b0; step(2);
    apply_reset();
    pg_if.Trigger_in = 1'b1; step(3); pg_if.Trigger_in = 1'b0; step(10);
    chk("post_rst_counts", int'(pg_if.Pulse_counts), 0);
    chk("post_rst_valid",  int'(pg_if.Pulse_valid),  0);

    // random traffic
    trig_cnt = 5;
    cap_cnt  = 200;
    for (int c = 0; c < 3000; c++) begin
      pg_if.Start = ($urandom_range(0, 24) == 0);
      pg_if.Abort = ($urandom_range(0, 199) == 0);
      if (trig_cnt == 0) begin
        pg_if.Trigger_in = ~pg_if.Trigger_in;
        trig_cnt = pg_if.Trigger_in ? $urandom_range(1, 4) : $urandom_range(2, 30);
      end else begin
        trig_cnt--;
      end
      if (cap_cnt == 0) begin
        pg_if.Capture_En = ~pg_if.Capture_En;
        cap_cnt = pg_if.Capture_En ? $urandom_range(100, 400) : $urandom_range(1, 5);
      end else begin
        cap_cnt--;
      end
      step(1);
    end
    pg_if.Start = 1'b0;
    pg_if.Abort = 1'b0;
    pg_if.Capture_En = 1'b1;
    pg_if.Trigger_in = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
